// File: rtl/kgp_fetch_pkg.sv
// Shared fetch widths, PC step, default reset PC and output-buffer depth.
// IFETCH_SKID_EN selects the two-entry skid buffer (full rate); otherwise one entry (half rate).
package kgp_fetch_pkg;

    localparam int               INSTR_W          = 32;
    localparam int               PC_W             = 32;
    localparam logic [PC_W-1:0]  PC_INC           = 32'd4;
    localparam logic [PC_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef IFETCH_SKID_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order shift buffer of fetched {instr, pc}; head is a register, push lands in one cycle.
// Caller guarantees no push when full; flush empties it and wins over push, pop still retires the head.
module fetch_buffer
    import kgp_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  fetch_entry_t       push_dat_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [OCC_W-1:0]   occ_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [PC_W-1:0]    head_pc_o
);

    fetch_entry_t     ent_q [DEPTH];
    fetch_entry_t     ent_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    int               wr_idx;

    always_comb begin
        ent_d  = ent_q;
        occ_d  = occ_q;
        wr_idx = int'(occ_q) - int'(pop_i);
        if (flush_i) begin
            // Stale words stay in place; the head is only meaningful while occ != 0.
            occ_d = '0;
        end else begin
            if (pop_i) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_d[i] = ent_q[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && (i == wr_idx)) begin
                    ent_d[i] = push_dat_i;
                end
            end
            occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            ent_q <= ent_d;
        end
    end

    assign occ_o        = occ_q;
    assign head_instr_o = ent_q[0].instr;
    assign head_pc_o    = ent_q[0].pc;

endmodule

// File: rtl/instruction_fetch.sv
// Sequential PC fetch against a 1-cycle imem; first instr two cycles after reset/redirect.
// Issue throttled so buffered + in-flight never exceeds depth (IFETCH_SKID_EN: 2, else 1); drains with fetch_en low.
module instruction_fetch
    import kgp_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready
);

    localparam int DEPTH = FETCH_DEPTH;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic             pop;
    fetch_entry_t     push_dat;

    assign instr_valid = (occ != '0);
    assign pop         = instr_valid && instr_ready;
    assign imem_addr   = pc_q;
    assign push_dat    = '{instr: imem_data, pc: req_pc_q};

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (fetch_en && ((int'(occ) + int'(inflight_q)) < (DEPTH + int'(pop)))) begin
            // Reserve a slot now for the word that returns next cycle.
            pc_d       = pc_q + PC_INC;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (inflight_q),
        .push_dat_i   (push_dat),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .occ_o        (occ),
        .head_instr_o (instr),
        .head_pc_o    (instr_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and random stimulus for instruction_fetch checked against a queue-based reference model;
// a second instance with RESET_PC near the top of memory exercises PC wrap.
module tb_instruction_fetch;

`ifdef IFETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, fetch_en, redirect_valid, instr_ready;
    logic [31:0] redirect_pc, imem_addr, imem_data, instr, instr_pc;
    logic        instr_valid;

    logic [31:0] w_addr, w_data, w_instr, w_pc;
    logic        w_valid;

    int checks = 0;
    int fails  = 0;

    // Reference model: fetch PC, the one outstanding request, and buffered PCs in order.
    logic [31:0] m_pc, m_req_pc;
    bit          m_inflight;
    logic [31:0] q_pc [$];

    logic [31:0] wrap_pc_q  [$];
    logic [31:0] wrap_ins_q [$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) imem_data <= mem_word(imem_addr);
    always @(posedge clk) w_data    <= mem_word(w_addr);

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_addr      (w_addr),
        .imem_data      (w_data),
        .instr_valid    (w_valid),
        .instr          (w_instr),
        .instr_pc       (w_pc),
        .instr_ready    (1'b1)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && w_valid === 1'b1 && wrap_pc_q.size() < 4) begin
            wrap_pc_q.push_back(w_pc);
            wrap_ins_q.push_back(w_instr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int occ_now;
        bit pop;
        bit issue;
        if (!rst_n) begin
            m_pc       = RST_PC;
            m_inflight = 1'b0;
            q_pc.delete();
            return;
        end
        occ_now = q_pc.size();
        pop     = (occ_now != 0) && instr_ready;
        if (pop) void'(q_pc.pop_front());
        if (redirect_valid) begin
            q_pc.delete();
            m_inflight = 1'b0;
            m_pc       = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            issue = fetch_en && ((occ_now + int'(m_inflight) - int'(pop)) < DEPTH);
            if (m_inflight) q_pc.push_back(m_req_pc);
            if (issue) begin
                m_req_pc   = m_pc;
                m_pc       = m_pc + 32'd4;
                m_inflight = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            chk("instr_pc", instr_pc, q_pc[0]);
            chk("instr", instr, mem_word(q_pc[0]));
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge after checking.
    task automatic cycle();
        bit was_rst;
        was_rst = !rst_n;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (was_rst) begin
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
        end
    endtask

    initial begin
        logic        v1, v2;
        bit          found;
        logic [31:0] exp_w [4];

        rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h55;
        instr_ready = 1'b1;
        m_pc = RST_PC; m_req_pc = '0; m_inflight = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        redirect_valid = 1'b0;

        // Release reset: first valid two cycles later, back-to-back in skid build.
        rst_n = 1'b1;
        cycle(); v1 = instr_valid;
        cycle(); v2 = instr_valid;
        chk("first_valid_c1", 32'(v1), 32'd0);
        chk("first_valid_c2", 32'(v2), 32'd1);

        // Stall decode for 3 cycles while instr_pc 0x8 is at the head.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid && instr_pc == 32'h8) found = 1'b1;
            else cycle();
        end
        chk("saw_pc8", 32'(found), 32'd1);
        instr_ready = 1'b0;
        repeat (3) cycle();
        chk("stall_hold_pc", instr_pc, 32'h8);
`ifdef IFETCH_SKID_EN
        chk("stall_frozen_addr", imem_addr, 32'h10);
`endif
        instr_ready = 1'b1;
        repeat (3) cycle();

        // Fill the buffer, then redirect to an unaligned target.
        instr_ready = 1'b0;
        repeat (2) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_flushed", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        repeat (2) cycle();
        chk("redir_first_valid", 32'(instr_valid), 32'd1);
        chk("redir_first_pc", instr_pc, 32'h100);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;

        // One-cycle reset pulse mid-stream with a redirect asserted.
        fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (4) cycle();
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_4444;
        cycle();
        chk("pulse_addr", imem_addr, RST_PC);
        chk("pulse_valid", 32'(instr_valid), 32'd0);
        rst_n = 1'b1; redirect_valid = 1'b0;
        repeat (2) cycle();
        chk("pulse_restart_valid", 32'(instr_valid), 32'd1);
        chk("pulse_restart_pc", instr_pc, RST_PC);
        repeat (6) cycle();

        // Wrap instance: PC sequence crosses 2^32.
        exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000; exp_w[3] = 32'h0000_0004;
        chk("wrap_count", wrap_pc_q.size(), 32'd4);
        if (wrap_pc_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("wrap_pc", wrap_pc_q[i], exp_w[i]);
                chk("wrap_instr", wrap_ins_q[i], mem_word(exp_w[i]));
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
